// File: rtl/qnigma_pkg.sv
// Shared types for the qnigma DNS path: hostname/address types,
// arbiter state encoding and the single-entry result cache record.
package qnigma_pkg;

    localparam int HOST_LEN = 16;
    localparam int HOST_LW  = $clog2(HOST_LEN + 1);

    typedef struct packed {
        logic [HOST_LEN*8-1:0] str;
        logic [HOST_LW-1:0]    lng;
    } hostname_t;

    typedef logic [127:0] ip_t;

    localparam int DNS_ARB_CLI_MAX = 8;
    localparam int DNS_ARB_AGE_W   = 16;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_DONE
    } dns_arb_state_t;

    typedef struct packed {
        logic                     vld;
        hostname_t                host;
        ip_t                      addr;
        logic [DNS_ARB_AGE_W-1:0] age;
    } dns_arb_cache_t;

endpackage

// File: rtl/qnigma_rr_arb.sv
// Round-robin one-hot picker: first set request at or after ptr,
// wrapping modulo N. Purely combinational.
module qnigma_rr_arb #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         hit
);

    logic [W-1:0] j;

    always_comb begin
        gnt = '0;
        idx = '0;
        hit = 1'b0;
        j   = '0;
        for (int i = 0; i < N; i++) begin
            j = W'((int'(ptr) + i) % N);
            if (!hit && req[j]) begin
                hit    = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/qnigma_dns_arb.sv
// Round-robin arbiter sharing one DNS resolver among N_CLI clients.
// Optional one-entry result cache: define QNIGMA_DNS_ARB_CACHE_EN.
module qnigma_dns_arb
    import qnigma_pkg::*;
#(
    parameter int N_CLI         = 4,
    parameter int ARB_TIMEOUT_S = 10,
    parameter int CACHE_TTL_S   = 60
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_s,
    input  logic [N_CLI-1:0]      cli_req,
    input  hostname_t [N_CLI-1:0] cli_hst,
    output logic [N_CLI-1:0]      cli_gnt,
    output logic [N_CLI-1:0]      cli_done,
    output logic                  cli_err,
    output ip_t                   cli_addr,
    output hostname_t             res_hostname,
    output logic                  res_req,
    input  logic                  res_acc,
    input  logic                  res_val,
    input  logic                  res_err,
    input  ip_t                   res_addr,
    output logic                  busy
);

    localparam int PW = $clog2(N_CLI);
    localparam int WW = $clog2(ARB_TIMEOUT_S + 1);
    localparam logic [WW-1:0] WD_MAX = WW'(ARB_TIMEOUT_S);

    dns_arb_state_t state, nxt;

    logic [N_CLI-1:0] pick_gnt;
    logic [PW-1:0]    pick_idx;
    logic             pick_hit;
    logic [PW-1:0]    rr;
    logic [PW-1:0]    idx;
    logic [WW-1:0]    wd;
    logic             prev_err;
    logic             acc_err;
    logic             fin_ok;
    logic             fin_err;
    logic             cache_hit;
    ip_t              cache_addr;

    qnigma_rr_arb #(.N(N_CLI)) u_pick (
        .req (cli_req),
        .ptr (rr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .hit (pick_hit)
    );

`ifdef QNIGMA_DNS_ARB_CACHE_EN
    localparam logic [DNS_ARB_AGE_W-1:0] TTL = DNS_ARB_AGE_W'(CACHE_TTL_S);

    dns_arb_cache_t cache;

    always_ff @(posedge clk) begin
        if (rst) begin
            cache <= '0;
        end else if (state == ARB_WAIT && fin_ok) begin
            cache.vld  <= 1'b1;
            cache.host <= res_hostname;
            cache.addr <= res_addr;
            cache.age  <= '0;
        end else if (tick_s && cache.age != TTL) begin
            cache.age <= cache.age + 1'b1;
        end
    end

    assign cache_hit  = cache.vld && (cache.age < TTL) &&
                        (cli_hst[pick_idx] == cache.host);
    assign cache_addr = cache.addr;
`else
    assign cache_hit  = 1'b0;
    assign cache_addr = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= ARB_IDLE;
        else     state <= nxt;
    end

    // res_val outranks any error seen in the same cycle
    always_comb begin
        nxt     = state;
        fin_ok  = 1'b0;
        fin_err = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (pick_hit) nxt = cache_hit ? ARB_DONE : ARB_ISSUE;
            end
            ARB_ISSUE: begin
                if (res_acc) nxt = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (res_val) begin
                    fin_ok = 1'b1;
                    nxt    = ARB_DONE;
                end else if ((res_err && !prev_err) || acc_err ||
                             wd == WD_MAX) begin
                    fin_err = 1'b1;
                    nxt     = ARB_DONE;
                end
            end
            ARB_DONE: nxt = ARB_IDLE;
            default:  nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cli_gnt      <= '0;
            cli_done     <= '0;
            cli_err      <= 1'b0;
            cli_addr     <= '0;
            res_hostname <= '0;
            res_req      <= 1'b0;
            rr           <= '0;
            idx          <= '0;
            wd           <= '0;
            prev_err     <= 1'b0;
            acc_err      <= 1'b0;
        end else begin
            cli_done <= '0;
            if (tick_s && wd != WD_MAX &&
                (state == ARB_ISSUE || state == ARB_WAIT))
                wd <= wd + 1'b1;
            unique case (state)
                ARB_IDLE: begin
                    if (pick_hit) begin
                        idx          <= pick_idx;
                        cli_gnt      <= pick_gnt;
                        res_hostname <= cli_hst[pick_idx];
                        wd           <= '0;
                        acc_err      <= 1'b0;
                        if (cache_hit) begin
                            cli_done <= pick_gnt;
                            cli_err  <= 1'b0;
                            cli_addr <= cache_addr;
                        end else begin
                            res_req <= 1'b1;
                        end
                    end
                end
                ARB_ISSUE: begin
                    if (res_acc) begin
                        res_req  <= 1'b0;
                        prev_err <= res_err;
                        acc_err  <= res_err;
                    end
                end
                ARB_WAIT: begin
                    prev_err <= res_err;
                    if (fin_ok) begin
                        cli_done <= cli_gnt;
                        cli_err  <= 1'b0;
                        cli_addr <= res_addr;
                    end else if (fin_err) begin
                        cli_done <= cli_gnt;
                        cli_err  <= 1'b1;
                    end
                end
                ARB_DONE: begin
                    cli_gnt <= '0;
                    rr      <= (idx == PW'(N_CLI - 1)) ? '0 : idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != ARB_IDLE);

endmodule

// File: tb/tb_qnigma_dns_arb.sv
// Directed bench for qnigma_dns_arb: vector table for arbitration
// and resolver outcomes, plus watchdog, reset and cache sequences.
module tb_qnigma_dns_arb;
    import qnigma_pkg::*;

    localparam int N        = 4;
    localparam int M_OK     = 0;
    localparam int M_ERR    = 1;
    localparam int M_TMO    = 2;
    localparam int M_ACCERR = 3;
    localparam int M_BOTH   = 4;

    localparam ip_t A1 = 128'h2001_0db8_0000_0000_0000_0000_0000_0001;
    localparam ip_t A3 = 128'h2001_0db8_0000_0000_0000_0000_0000_0003;
    localparam ip_t A4 = 128'hfe80_0000_0000_0000_0000_0000_0000_0004;
    localparam ip_t A6 = 128'h2001_0db8_00aa_0000_0000_0000_0000_0006;
    localparam ip_t A7 = 128'h2001_0db8_0000_0000_0000_0000_0000_0007;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                tick_s = 1'b0;
    logic [N-1:0]        cli_req = '0;
    hostname_t [N-1:0]   cli_hst = '0;
    logic [N-1:0]        cli_gnt;
    logic [N-1:0]        cli_done;
    logic                cli_err;
    ip_t                 cli_addr;
    hostname_t           res_hostname;
    logic                res_req;
    logic                res_acc = 1'b0;
    logic                res_val = 1'b0;
    logic                res_err = 1'b0;
    ip_t                 res_addr = '0;
    logic                busy;

    always #5 clk = ~clk;

    qnigma_dns_arb #(.N_CLI(N), .ARB_TIMEOUT_S(10), .CACHE_TTL_S(60)) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_s       (tick_s),
        .cli_req      (cli_req),
        .cli_hst      (cli_hst),
        .cli_gnt      (cli_gnt),
        .cli_done     (cli_done),
        .cli_err      (cli_err),
        .cli_addr     (cli_addr),
        .res_hostname (res_hostname),
        .res_req      (res_req),
        .res_acc      (res_acc),
        .res_val      (res_val),
        .res_err      (res_err),
        .res_addr     (res_addr),
        .busy         (busy)
    );

    int   checks = 0;
    int   failures = 0;
    int   req_rises = 0;
    int   done_cnt = 0;
    logic req_q = 1'b0;
    logic tmo_early;
    logic tmo_now;

    always @(negedge clk) begin
        req_q <= res_req;
        if (res_req && !req_q) req_rises <= req_rises + 1;
        if (cli_done != 0) done_cnt <= done_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cli_req = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic hostname_t host_of(input string s);
        hostname_t h;
        h = '0;
        for (int i = 0; i < s.len(); i++)
            h.str[(HOST_LEN-1-i)*8 +: 8] = s[i];
        h.lng = HOST_LW'(s.len());
        return h;
    endfunction

    function automatic int oh2i(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Plays the resolver for one transaction; acc arrives 2 cycles after req.
    task automatic serve(input int mode, input int dly, input ip_t addr,
                         output int gidx, output hostname_t hn,
                         output logic err, output ip_t a, output logic ok);
        ok = 1'b0;
        gidx = -1;
        hn = '0;
        err = 1'b0;
        a = '0;
        tmo_early = 1'b0;
        tmo_now = 1'b0;
        for (int i = 0; i < 30 && !res_req; i++) step();
        if (!res_req) begin
            chk("res_req_seen", 0, 1);
            return;
        end
        gidx = oh2i(cli_gnt);
        hn = res_hostname;
        repeat (2) step();
        res_acc = 1'b1;
        if (mode == M_ACCERR) res_err = 1'b1;
        step();
        res_acc = 1'b0;
        res_err = 1'b0;
        chk("res_req_drop", res_req, 0);
        if (mode == M_TMO) begin
            for (int t = 1; t <= 10; t++) begin
                if (cli_done != 0) tmo_early = 1'b1;
                tick_s = 1'b1;
                step();
                tick_s = 1'b0;
                step();
            end
            tmo_now = (cli_done != 0);
        end else if (mode != M_ACCERR) begin
            repeat (dly - 1) step();
            res_addr = addr;
            if (mode == M_OK || mode == M_BOTH) res_val = 1'b1;
            if (mode == M_ERR || mode == M_BOTH) res_err = 1'b1;
            step();
            res_val = 1'b0;
            res_err = 1'b0;
        end
        for (int i = 0; i < 8 && cli_done == 0; i++) step();
        if (cli_done == 0) begin
            chk("done_seen", 0, 1);
            return;
        end
        chk("done_matches_gnt", cli_done, cli_gnt);
        err = cli_err;
        a = cli_addr;
        ok = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] req;
        int           mode;
        int           dly;
        ip_t          addr;
        int           exp_gnt;
        logic         exp_err;
    } vec_t;

    vec_t      vt[7];
    hostname_t names[N];

    initial begin
        int        g;
        hostname_t hn;
        logic      e;
        ip_t       a;
        logic      ok;
        int        r0;
        int        d0;

        names[0] = host_of("a.io");
        names[1] = host_of("bb.net");
        names[2] = host_of("c.org");
        names[3] = host_of("dddd.example");
        for (int i = 0; i < N; i++) cli_hst[i] = names[i];

        vt[0] = '{4'b1011, M_OK,     5,  A1, 0, 1'b0};
        vt[1] = '{4'b1011, M_ERR,    10, '0, 1, 1'b1};
        vt[2] = '{4'b1011, M_OK,     3,  A3, 3, 1'b0};
        vt[3] = '{4'b1011, M_OK,     7,  A4, 0, 1'b0};
        vt[4] = '{4'b0110, M_ACCERR, 1,  '0, 1, 1'b1};
        vt[5] = '{4'b0110, M_BOTH,   4,  A6, 2, 1'b0};
        vt[6] = '{4'b0011, M_OK,     2,  A7, 0, 1'b0};

        rst = 1'b1;
        step();
        step();
        chk("rst_gnt", cli_gnt, 0);
        chk("rst_done", cli_done, 0);
        chk("rst_err", cli_err, 0);
        chk("rst_addr", cli_addr, 0);
        chk("rst_req", res_req, 0);
        chk("rst_host", res_hostname == '0, 1);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // single client, slow resolver
        r0 = req_rises;
        d0 = done_cnt;
        cli_req = 4'b0001;
        serve(M_OK, 50, A1, g, hn, e, a, ok);
        cli_req = '0;
        step();
        chk("single_gnt", g, 0);
        chk("single_host", hn == names[0], 1);
        chk("single_err", e, 0);
        chk("single_addr", a, A1);
        chk("single_req_once", req_rises - r0, 1);
        chk("single_done_once", done_cnt - d0, 1);
        chk("single_idle", busy, 0);

        do_reset();
        for (int v = 0; v < 7; v++) begin
            cli_req = vt[v].req;
            r0 = req_rises;
            serve(vt[v].mode, vt[v].dly, vt[v].addr, g, hn, e, a, ok);
            if (ok) begin
                chk($sformatf("v%0d_gnt", v), g, vt[v].exp_gnt);
                chk($sformatf("v%0d_host", v), hn == names[vt[v].exp_gnt], 1);
                chk($sformatf("v%0d_err", v), e, vt[v].exp_err);
                if (!vt[v].exp_err)
                    chk($sformatf("v%0d_addr", v), a, vt[v].addr);
            end
            step();
            chk($sformatf("v%0d_pulse", v), cli_done, 0);
            chk($sformatf("v%0d_gnt_clr", v), cli_gnt, 0);
            chk($sformatf("v%0d_req_once", v), req_rises - r0, 1);
        end
        cli_req = '0;
        step();

        // watchdog: rr now points at client 1
        cli_req = 4'b0010;
        serve(M_TMO, 0, '0, g, hn, e, a, ok);
        cli_req = '0;
        chk("tmo_gnt", g, 1);
        chk("tmo_err", e, 1);
        chk("tmo_not_early", tmo_early, 0);
        chk("tmo_at_10th", tmo_now, 1);
        step();
        chk("tmo_idle", busy, 0);

        // reset while waiting on the resolver
        cli_req = 4'b0100;
        for (int i = 0; i < 30 && !res_req; i++) step();
        chk("rw_req", res_req, 1);
        repeat (2) step();
        res_acc = 1'b1;
        step();
        res_acc = 1'b0;
        repeat (5) step();
        chk("rw_busy", busy, 1);
        d0 = done_cnt;
        rst = 1'b1;
        cli_req = '0;
        step();
        rst = 1'b0;
        chk("rw_gnt", cli_gnt, 0);
        chk("rw_done", cli_done, 0);
        chk("rw_err", cli_err, 0);
        chk("rw_addr", cli_addr, 0);
        chk("rw_res_req", res_req, 0);
        chk("rw_host", res_hostname == '0, 1);
        chk("rw_busy0", busy, 0);
        r0 = req_rises;
        res_addr = A3;
        res_val = 1'b1;
        step();
        res_val = 1'b0;
        repeat (20) step();
        chk("rw_no_done", done_cnt - d0, 0);
        chk("rw_no_req", req_rises - r0, 0);
        cli_req = 4'b0100;
        serve(M_OK, 3, A3, g, hn, e, a, ok);
        cli_req = '0;
        chk("rw_regrant", g, 2);
        chk("rw_new_req", req_rises - r0, 1);
        chk("rw_addr_ok", a, A3);
        step();

`ifdef QNIGMA_DNS_ARB_CACHE_EN
        do_reset();
        cli_req = 4'b0001;
        serve(M_OK, 4, A1, g, hn, e, a, ok);
        cli_req = '0;
        step();
        repeat (5) begin
            tick_s = 1'b1;
            step();
            tick_s = 1'b0;
            step();
        end
        cli_hst[2] = names[0];
        r0 = req_rises;
        cli_req = 4'b0100;
        for (int i = 0; i < 10 && cli_done == 0; i++) step();
        chk("c_hit_done", cli_done, 4'b0100);
        chk("c_hit_addr", cli_addr, A1);
        chk("c_hit_err", cli_err, 0);
        cli_req = '0;
        step();
        step();
        chk("c_hit_no_req", req_rises - r0, 0);
        repeat (56) begin
            tick_s = 1'b1;
            step();
            tick_s = 1'b0;
            step();
        end
        r0 = req_rises;
        cli_req = 4'b0100;
        serve(M_OK, 3, A3, g, hn, e, a, ok);
        cli_req = '0;
        chk("c_exp_req", req_rises - r0, 1);
        chk("c_exp_addr", a, A3);
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
